// File: rtl/dnn_eval_pkg.sv
// Shared constants for the output evaluator: default parameter values,
// the fixed 16-bit epoch / per-neuron error counter widths, and a helper
// that sizes index registers so that a depth of 1 still yields a 1-bit index.
package dnn_eval_pkg;

  localparam int DEF_N_OUT          = 16;
  localparam int DEF_CHECKLAST      = 1000;
  localparam int DEF_TRAINING_CASES = 10000;
  localparam int DEF_TOTAL_CASES    = 100000;

  localparam int EPOCH_W = 16;
  localparam int ERR_W   = 16;

  // Width of an index that counts 0..n-1 (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_history.sv
// Moving-window history ring: one result bit per committed case.
// old_bit is the entry about to be overwritten (read before write). Entries
// not yet written since reset read as 0, tracked by a "filled" flag so the
// storage array itself needs no reset and can map onto RAM.
module result_history
  import dnn_eval_pkg::*;
#(
  parameter int DEPTH = DEF_CHECKLAST
)(
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic wdata,
  output logic old_bit
);

  localparam int PTR_W = idx_width(DEPTH);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic             filled_reg;

  // Storage write: one bit per commit at the current pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_reg] <= wdata;
    end
  end

  // Pointer advance with wrap; filled marks that every entry has been written once.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg    <= '0;
      filled_reg <= 1'b0;
    end else if (we) begin
      if (ptr_reg == PTR_W'(DEPTH - 1)) begin
        ptr_reg    <= '0;
        filled_reg <= 1'b1;
      end else begin
        ptr_reg <= ptr_reg + 1'b1;
      end
    end
  end

  assign old_bit = filled_reg & mem[ptr_reg];

endmodule

// File: rtl/output_evaluator.sv
// Output evaluator: assembles the ideal output vector one bit per y_valid,
// captures the network outputs on the last bit of a case, and one cycle later
// commits the result into accuracy, window, epoch and stop counters.
// Optional feature macro: EVAL_NEURON_ERR_EN adds per-neuron mismatch
// counters on port neuron_err.
module output_evaluator
  import dnn_eval_pkg::*;
#(
  parameter int N_OUT          = DEF_N_OUT,
  parameter int CHECKLAST      = DEF_CHECKLAST,
  parameter int TRAINING_CASES = DEF_TRAINING_CASES,
  parameter int TOTAL_CASES    = DEF_TOTAL_CASES
)(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               y_valid,
  input  logic                               y_out,
  input  logic [N_OUT-1:0]                   a_out_alln,
  output logic                               case_done,
  output logic                               correct,
  output logic [$clog2(CHECKLAST+1)-1:0]     recent,
  output logic [$clog2(TOTAL_CASES+1)-1:0]   total_correct,
  output logic [$clog2(TOTAL_CASES+1)-1:0]   num_train,
  output logic [EPOCH_W-1:0]                 epoch,
  output logic                               epoch_done,
  output logic                               eval_done
`ifdef EVAL_NEURON_ERR_EN
  ,
  output logic [N_OUT*ERR_W-1:0]             neuron_err
`endif
);

  localparam int IDX_W = idx_width(N_OUT);
  localparam int REC_W = $clog2(CHECKLAST + 1);
  localparam int CNT_W = $clog2(TOTAL_CASES + 1);
  localparam int EPC_W = idx_width(TRAINING_CASES);

  logic [IDX_W-1:0] idx_reg;
  logic [N_OUT-1:0] ideal_reg;
  logic [N_OUT-1:0] ideal_next;
  logic [N_OUT-1:0] cap_a_reg;
  logic [N_OUT-1:0] cap_y_reg;
  logic             commit_reg;
  logic [EPC_W-1:0] ep_cnt_reg;

  logic             accept;
  logic             last_bit;
  logic [N_OUT-1:0] diff;
  logic             match;
  logic             old_bit;
  logic [REC_W-1:0] recent_next;

  // Input-side decode: bit acceptance, end-of-case detect, ideal vector with current bit merged.
  always_comb begin
    accept              = y_valid & ~eval_done;
    last_bit            = (idx_reg == IDX_W'(N_OUT - 1));
    ideal_next          = ideal_reg;
    ideal_next[idx_reg] = y_out;
  end

  // Commit-side decode: compare the captured vectors and form the new window count.
  always_comb begin
    diff        = cap_a_reg ^ cap_y_reg;
    match       = ~|diff;
    recent_next = recent - REC_W'(old_bit) + REC_W'(match);
  end

  // Bit assembly and capture; the capture arms a commit for the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg    <= '0;
      ideal_reg  <= '0;
      cap_a_reg  <= '0;
      cap_y_reg  <= '0;
      commit_reg <= 1'b0;
    end else begin
      commit_reg <= 1'b0;
      if (accept) begin
        ideal_reg <= ideal_next;
        if (last_bit) begin
          idx_reg    <= '0;
          cap_a_reg  <= a_out_alln;
          cap_y_reg  <= ideal_next;
          commit_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  result_history #(
    .DEPTH (CHECKLAST)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .we      (commit_reg),
    .wdata   (match),
    .old_bit (old_bit)
  );

  // Result commit: pulses, accuracy counters, epoch tracking and the sticky stop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      case_done     <= 1'b0;
      epoch_done    <= 1'b0;
      correct       <= 1'b0;
      recent        <= '0;
      total_correct <= '0;
      num_train     <= '0;
      ep_cnt_reg    <= '0;
      epoch         <= EPOCH_W'(1);
      eval_done     <= 1'b0;
    end else begin
      case_done  <= 1'b0;
      epoch_done <= 1'b0;
      if (commit_reg) begin
        case_done     <= 1'b1;
        correct       <= match;
        recent        <= recent_next;
        total_correct <= total_correct + CNT_W'(match);
        num_train     <= num_train + 1'b1;
        if (ep_cnt_reg == EPC_W'(TRAINING_CASES - 1)) begin
          ep_cnt_reg <= '0;
          epoch_done <= 1'b1;
          epoch      <= epoch + 1'b1;
        end else begin
          ep_cnt_reg <= ep_cnt_reg + 1'b1;
        end
        if (num_train == CNT_W'(TOTAL_CASES - 1)) begin
          eval_done <= 1'b1;
        end
      end
    end
  end

`ifdef EVAL_NEURON_ERR_EN
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_err
    logic [ERR_W-1:0] err_reg;

    // Per-neuron mismatch counter, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (reset) begin
        err_reg <= '0;
      end else if (commit_reg && diff[gi] && (err_reg != {ERR_W{1'b1}})) begin
        err_reg <= err_reg + 1'b1;
      end
    end

    assign neuron_err[gi*ERR_W +: ERR_W] = err_reg;
  end
`endif

endmodule

// File: tb/tb_output_evaluator.sv
// Directed testbench for output_evaluator. Two instances share the stimulus:
// dut_a has a 4-case accuracy window (default epoch/stop sizes), dut_b has
// 3-case epochs and stops after 5 cases.
module tb_output_evaluator;

  localparam int A_REC_W = $clog2(4 + 1);
  localparam int A_CNT_W = $clog2(100000 + 1);
  localparam int B_REC_W = $clog2(1000 + 1);
  localparam int B_CNT_W = $clog2(5 + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        y_valid = 1'b0;
  logic        y_out = 1'b0;
  logic [15:0] a_out_alln = '0;

  logic               a_case_done, a_correct, a_epoch_done, a_eval_done;
  logic [A_REC_W-1:0] a_recent;
  logic [A_CNT_W-1:0] a_total_correct, a_num_train;
  logic [15:0]        a_epoch;

  logic               b_case_done, b_correct, b_epoch_done, b_eval_done;
  logic [B_REC_W-1:0] b_recent;
  logic [B_CNT_W-1:0] b_total_correct, b_num_train;
  logic [15:0]        b_epoch;

`ifdef EVAL_NEURON_ERR_EN
  logic [16*16-1:0] a_neuron_err, b_neuron_err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_rec [6] = '{1, 2, 3, 4, 3, 2};

  always #5 clk = ~clk;

  output_evaluator #(
    .N_OUT (16), .CHECKLAST (4), .TRAINING_CASES (10000), .TOTAL_CASES (100000)
  ) dut_a (
    .clk (clk), .reset (reset), .y_valid (y_valid), .y_out (y_out),
    .a_out_alln (a_out_alln), .case_done (a_case_done), .correct (a_correct),
    .recent (a_recent), .total_correct (a_total_correct), .num_train (a_num_train),
    .epoch (a_epoch), .epoch_done (a_epoch_done), .eval_done (a_eval_done)
`ifdef EVAL_NEURON_ERR_EN
    , .neuron_err (a_neuron_err)
`endif
  );

  output_evaluator #(
    .N_OUT (16), .CHECKLAST (1000), .TRAINING_CASES (3), .TOTAL_CASES (5)
  ) dut_b (
    .clk (clk), .reset (reset), .y_valid (y_valid), .y_out (y_out),
    .a_out_alln (a_out_alln), .case_done (b_case_done), .correct (b_correct),
    .recent (b_recent), .total_correct (b_total_correct), .num_train (b_num_train),
    .epoch (b_epoch), .epoch_done (b_epoch_done), .eval_done (b_eval_done)
`ifdef EVAL_NEURON_ERR_EN
    , .neuron_err (b_neuron_err)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; y_valid = 1'b0; y_out = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives nbits ideal bits LSB-first, then drops y_valid; the last bit is
  // captured on the edge just before return, commit shows one negedge later.
  task automatic send_case(input logic [15:0] y, input logic [15:0] a, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      y_valid = 1'b1; y_out = y[i]; a_out_alln = a;
    end
    @(negedge clk);
    y_valid = 1'b0; y_out = 1'b0;
    $display("case y=%h a=%h bits=%0d", y, a, nbits);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (a_case_done !== 1'b0) $display("FAIL rst_case_done: got %0b want 0", a_case_done); else pass_cnt++;
    total_cnt++; if (a_correct !== 1'b0) $display("FAIL rst_correct: got %0b want 0", a_correct); else pass_cnt++;
    total_cnt++; if (a_recent !== '0) $display("FAIL rst_recent: got %0d want 0", a_recent); else pass_cnt++;
    total_cnt++; if (a_num_train !== '0) $display("FAIL rst_num_train: got %0d want 0", a_num_train); else pass_cnt++;
    total_cnt++; if (a_total_correct !== '0) $display("FAIL rst_total: got %0d want 0", a_total_correct); else pass_cnt++;
    total_cnt++; if (a_epoch !== 16'd1) $display("FAIL rst_epoch: got %0d want 1", a_epoch); else pass_cnt++;
    total_cnt++; if (a_eval_done !== 1'b0 || a_epoch_done !== 1'b0) $display("FAIL rst_flags: got eval=%0b ep=%0b want 0 0", a_eval_done, a_epoch_done); else pass_cnt++;
  endtask

  task automatic test_correct_case();
    do_reset();
    send_case(16'h0004, 16'h0004, 16);
    total_cnt++; if (a_case_done !== 1'b0) $display("FAIL ok_early_done: got %0b want 0", a_case_done); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_case_done !== 1'b1) $display("FAIL ok_case_done: got %0b want 1", a_case_done); else pass_cnt++;
    total_cnt++; if (a_correct !== 1'b1) $display("FAIL ok_correct: got %0b want 1", a_correct); else pass_cnt++;
    total_cnt++; if (a_recent !== 3'd1) $display("FAIL ok_recent: got %0d want 1", a_recent); else pass_cnt++;
    total_cnt++; if (a_total_correct !== 17'd1) $display("FAIL ok_total: got %0d want 1", a_total_correct); else pass_cnt++;
    total_cnt++; if (a_num_train !== 17'd1) $display("FAIL ok_num_train: got %0d want 1", a_num_train); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (a_case_done !== 1'b0) $display("FAIL ok_pulse_width: got %0b want 0", a_case_done); else pass_cnt++;
  endtask

  task automatic test_wrong_case();
    do_reset();
    send_case(16'h0004, 16'h0008, 16);
    @(negedge clk);
    total_cnt++; if (a_case_done !== 1'b1) $display("FAIL bad_case_done: got %0b want 1", a_case_done); else pass_cnt++;
    total_cnt++; if (a_correct !== 1'b0) $display("FAIL bad_correct: got %0b want 0", a_correct); else pass_cnt++;
    total_cnt++; if (a_recent !== 3'd0) $display("FAIL bad_recent: got %0d want 0", a_recent); else pass_cnt++;
    total_cnt++; if (a_total_correct !== 17'd0) $display("FAIL bad_total: got %0d want 0", a_total_correct); else pass_cnt++;
    total_cnt++; if (a_num_train !== 17'd1) $display("FAIL bad_num_train: got %0d want 1", a_num_train); else pass_cnt++;
`ifdef EVAL_NEURON_ERR_EN
    total_cnt++; if (a_neuron_err[2*16 +: 16] !== 16'd1) $display("FAIL err_n2: got %0d want 1", a_neuron_err[2*16 +: 16]); else pass_cnt++;
    total_cnt++; if (a_neuron_err[3*16 +: 16] !== 16'd1) $display("FAIL err_n3: got %0d want 1", a_neuron_err[3*16 +: 16]); else pass_cnt++;
    total_cnt++; if (a_neuron_err[0 +: 16] !== 16'd0) $display("FAIL err_n0: got %0d want 0", a_neuron_err[0 +: 16]); else pass_cnt++;
`endif
  endtask

  task automatic test_recent_window();
    logic [15:0] yv;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      yv = 16'h1234 + 16'(k);
      send_case(yv, (k < 4) ? yv : ~yv, 16);
      @(negedge clk);
      total_cnt++; if (a_recent !== 3'(exp_rec[k])) $display("FAIL win_recent_%0d: got %0d want %0d", k, a_recent, exp_rec[k]); else pass_cnt++;
      total_cnt++; if (a_correct !== (k < 4)) $display("FAIL win_correct_%0d: got %0b want %0b", k, a_correct, (k < 4)); else pass_cnt++;
    end
    total_cnt++; if (a_total_correct !== 17'd4) $display("FAIL win_total: got %0d want 4", a_total_correct); else pass_cnt++;
  endtask

  // Seven back-to-back cases with y_valid held high on dut_b; the second case is wrong.
  task automatic test_back_to_back();
    int commits;
    int c;
    logic [15:0] yv;
    do_reset();
    commits = 0;
    for (int cyc = 0; cyc < 16*7 + 4; cyc++) begin
      @(negedge clk);
      if (b_case_done === 1'b1) begin
        commits++;
        $display("commit %0d num_train=%0d epoch=%0d epoch_done=%0b eval_done=%0b", commits, b_num_train, b_epoch, b_epoch_done, b_eval_done);
        total_cnt++; if (b_num_train !== B_CNT_W'(commits)) $display("FAIL b2b_num_train_%0d: got %0d want %0d", commits, b_num_train, commits); else pass_cnt++;
        total_cnt++; if (b_epoch_done !== (commits == 3)) $display("FAIL b2b_epoch_done_%0d: got %0b want %0b", commits, b_epoch_done, (commits == 3)); else pass_cnt++;
        total_cnt++; if (b_epoch !== ((commits >= 3) ? 16'd2 : 16'd1)) $display("FAIL b2b_epoch_%0d: got %0d want %0d", commits, b_epoch, (commits >= 3) ? 2 : 1); else pass_cnt++;
        total_cnt++; if (b_eval_done !== (commits == 5)) $display("FAIL b2b_eval_done_%0d: got %0b want %0b", commits, b_eval_done, (commits == 5)); else pass_cnt++;
      end
      if (cyc < 16*7) begin
        c  = cyc / 16;
        yv = 16'hA5C3 ^ 16'(c * 273);
        y_valid    = 1'b1;
        y_out      = yv[cyc % 16];
        a_out_alln = (c == 1) ? (yv ^ 16'h0001) : yv;
      end else begin
        y_valid = 1'b0; y_out = 1'b0;
      end
    end
    total_cnt++; if (commits != 5) $display("FAIL b2b_commits: got %0d want 5", commits); else pass_cnt++;
    total_cnt++; if (b_num_train !== 3'd5) $display("FAIL b2b_final_num_train: got %0d want 5", b_num_train); else pass_cnt++;
    total_cnt++; if (b_total_correct !== 3'd4) $display("FAIL b2b_total: got %0d want 4", b_total_correct); else pass_cnt++;
    total_cnt++; if (b_eval_done !== 1'b1) $display("FAIL b2b_eval_sticky: got %0b want 1", b_eval_done); else pass_cnt++;
    total_cnt++; if (b_epoch !== 16'd2) $display("FAIL b2b_final_epoch: got %0d want 2", b_epoch); else pass_cnt++;
  endtask

  task automatic test_reset_mid_case();
    int dones;
    logic [15:0] yv;
    do_reset();
    yv = 16'h00F0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      y_valid = 1'b1; y_out = yv[i]; a_out_alln = yv;
    end
    @(negedge clk);
    reset = 1'b1; y_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (a_num_train !== '0) $display("FAIL mid_num_train_rst: got %0d want 0", a_num_train); else pass_cnt++;
    dones = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (a_case_done === 1'b1) dones++;
      if (cyc < 16) begin
        y_valid = 1'b1; y_out = yv[cyc]; a_out_alln = yv;
      end else begin
        y_valid = 1'b0; y_out = 1'b0;
      end
    end
    $display("case y=%h a=%h after mid-case reset", yv, yv);
    total_cnt++; if (dones != 1) $display("FAIL mid_dones: got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (a_num_train !== 17'd1) $display("FAIL mid_num_train: got %0d want 1", a_num_train); else pass_cnt++;
    total_cnt++; if (a_correct !== 1'b1) $display("FAIL mid_correct: got %0b want 1", a_correct); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_correct_case();
    test_wrong_case();
    test_recent_window();
    test_back_to_back();
    test_reset_mid_case();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/output_evaluator.md
OUTPUT_EVALUATOR -- requirements
Module: output_evaluator

Interface
- REQ-001: Parameter N_OUT, default 16: output neurons per training case.
- REQ-002: Parameter CHECKLAST, default 1000: moving-accuracy window length, in cases.
- REQ-003: Parameter TRAINING_CASES, default 10000: cases per epoch.
- REQ-004: Parameter TOTAL_CASES, default 100000: cases before evaluation stops.
- REQ-005: clk  in  1  single clock; all logic on its rising edge.
- REQ-006: reset  in  1  synchronous, active-high.
- REQ-007: y_valid  in  1  one ideal-output bit is presented this cycle.
- REQ-008: y_out  in  1  ideal output bit of the neuron at the current internal index.
- REQ-009: a_out_alln  in  N_OUT  thresholded network outputs; sampled on the last y_valid of a case.
- REQ-010: case_done  out  1  one-cycle pulse: a case result has been committed.
- REQ-011: correct  out  1  result of the last committed case.
- REQ-012: recent  out  clog2(CHECKLAST+1)  number of correct cases in the last CHECKLAST cases.
- REQ-013: total_correct  out  clog2(TOTAL_CASES+1)  accumulated correct count.
- REQ-014: num_train  out  clog2(TOTAL_CASES+1)  number of committed cases.
- REQ-015: epoch  out  16  current epoch; starts at 1.
- REQ-016: epoch_done  out  1  one-cycle pulse, coincident with case_done, on the last case of an epoch.
- REQ-017: eval_done  out  1  sticky; set when num_train reaches TOTAL_CASES.

Function
- REQ-018: On each y_valid, y_out shall be written to bit idx of the ideal register, then idx shall increment; idx runs 0..N_OUT-1.
- REQ-019: When y_valid arrives with idx==N_OUT-1, idx shall wrap to 0 and a_out_alln shall be captured with the completed ideal vector, including the current bit.
- REQ-020: One cycle after that capture: correct = (captured a_out == captured ideal, all N_OUT bits), case_done=1, num_train+1, total_correct+correct.
- REQ-021: recent update on commit: recent_next = recent - hist[ptr] + correct; hist[ptr] <= correct; ptr wraps from CHECKLAST-1 to 0.
- REQ-022: Before CHECKLAST cases have been committed, the history entries not yet written shall read 0, so recent equals the number of correct cases so far.
- REQ-023: An epoch case counter shall count 0..TRAINING_CASES-1; on the commit that wraps it, epoch_done=1 and epoch+1.
- REQ-024: When the commit makes num_train==TOTAL_CASES, eval_done shall be set in the same cycle as case_done; all later y_valid shall be ignored and all counters frozen.
- REQ-025: A y_valid in the commit cycle shall be accepted normally as idx 0 of the next case; back-to-back cases shall need no idle cycle.
- REQ-026: Per-cycle stats shall cost no extra latency: capture-to-outputs is exactly 1 cycle.

Reset
- REQ-027: Reset shall clear idx, ideal, hist, ptr, recent, total_correct, num_train, the epoch case counter, case_done, epoch_done, correct and eval_done to 0, and set epoch to 1.
- REQ-028: Reset mid-case shall discard the partial case without committing a result.

Configuration
- REQ-029: With EVAL_NEURON_ERR_EN defined, port neuron_err (out, N_OUT*16) shall hold per-neuron mismatch counters. Each counter increments on commit when its bit differs, saturates at 16'hFFFF, and clears on reset.
- REQ-030: Without EVAL_NEURON_ERR_EN, neither neuron_err nor its logic shall exist.

Structure
- REQ-031: Shared package dnn_eval_pkg shall hold the default parameter constants and the 16-bit epoch/counter width localparams.
- REQ-032: The history ring shall be sub-module result_history: a CHECKLAST x 1 bit array with pointer, write enable and read-before-write old-bit output.

Verification
- REQ-033: Reset, then 16 y_valid with y_out=16'h0004 LSB-first and a_out_alln=16'h0004 -> 1 cycle after last y_valid: case_done=1, correct=1, recent=1, total_correct=1, num_train=1.
- REQ-034: Same case with a_out_alln=16'h0008 -> correct=0, recent=0, total_correct=0; with EVAL_NEURON_ERR_EN, neuron_err[2]=1 and neuron_err[3]=1.
- REQ-035: CHECKLAST=4, commit 4 correct then 2 wrong -> recent sequence 1,2,3,4,3,2.
- REQ-036: TRAINING_CASES=3, TOTAL_CASES=5, continuous y_valid -> epoch_done on case 3 with epoch 1->2; eval_done on case 5; further inputs leave num_train=5.
- REQ-037: Reset asserted after 7 of 16 bits, then a full case -> exactly one case_done, with num_train=1.
